// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 initiator: turns a req/gnt core request into SETUP/ACCESS
// transfers and returns a one-cycle response, with a PREADY-stall watchdog.
module apb_master_bridge #(
   parameter int unsigned APB_ADDR_WIDTH = 12,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                      HCLK,
   input  logic                      HRESET,
   input  logic                      req_i,
   input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
   input  logic                      req_we_i,
   input  logic [31:0]               req_wdata_i,
   output logic                      gnt_o,
   output logic                      rvalid_o,
   output logic [31:0]               rdata_o,
   output logic                      err_o,
   output logic                      timeout_o,
   output logic [APB_ADDR_WIDTH-1:0] PADDR,
   output logic [31:0]               PWDATA,
   output logic                      PWRITE,
   output logic                      PSEL,
   output logic                      PENABLE,
   input  logic [31:0]               PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StSetup  = 2'd1;
   localparam logic [1:0] StAccess = 2'd2;

   localparam logic                 WdEn    = (TIMEOUT_CYCLES != 0);
   // Wraps harmlessly when the watchdog is disabled; WdEn masks it.
   localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [1:0]                state_q, state_d;
   logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [31:0]               pwdata_q, pwdata_d;
   logic                      pwrite_q, pwrite_d;
   logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
   logic                      rvalid_q, rvalid_d;
   logic [31:0]               rdata_q, rdata_d;
   logic                      err_q, err_d;
   logic                      timeout_q, timeout_d;

   always_comb begin
      state_d   = state_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pwrite_d  = pwrite_q;
      cnt_d     = cnt_q;
      rvalid_d  = 1'b0;
      rdata_d   = rdata_q;
      err_d     = err_q;
      timeout_d = timeout_q;
      case (state_q)
         StIdle: begin
            if (req_i) begin
               paddr_d  = req_addr_i;
               pwdata_d = req_wdata_i;
               pwrite_d = req_we_i;
               state_d  = StSetup;
            end
         end
         StSetup: begin
            cnt_d   = '0;
            state_d = StAccess;
         end
         StAccess: begin
            // A ready slave wins over a watchdog expiring in the same cycle.
            if (PREADY) begin
               rvalid_d = 1'b1;
               rdata_d  = pwrite_q ? 32'h0 : PRDATA;
               err_d    = PSLVERR;
               state_d  = StIdle;
            end else if (WdEn && (cnt_q == CntLast)) begin
               rvalid_d  = 1'b1;
               rdata_d   = 32'h0;
               err_d     = 1'b1;
               timeout_d = 1'b1;
               state_d   = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q   <= StIdle;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pwrite_q  <= 1'b0;
         cnt_q     <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pwrite_q  <= pwrite_d;
         cnt_q     <= cnt_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         timeout_q <= timeout_d;
      end
   end

   // PSEL/PENABLE decode only registered state, so reset drops them asynchronously.
   assign gnt_o     = (state_q == StIdle) & req_i;
   assign PSEL      = (state_q == StSetup) | (state_q == StAccess);
   assign PENABLE   = (state_q == StAccess);
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign PWRITE    = pwrite_q;
   assign rvalid_o  = rvalid_q;
   assign rdata_o   = rdata_q;
   assign err_o     = err_q;
   assign timeout_o = timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: vector table, hand-written corner sequences and
// randomized transfers checked against a transaction-level response model.
module tb_apb_master_bridge;

   localparam int TO = 4;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        req_i;
   logic [11:0] req_addr_i;
   logic        req_we_i;
   logic [31:0] req_wdata_i;
   logic        gnt_o, rvalid_o, err_o, timeout_o;
   logic [31:0] rdata_o;
   logic [11:0] PADDR;
   logic [31:0] PWDATA, PRDATA;
   logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

   apb_master_bridge #(
      .APB_ADDR_WIDTH(12),
      .TIMEOUT_CYCLES(TO),
      .CNT_WIDTH(16)
   ) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .req_i(req_i), .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_wdata_i(req_wdata_i),
      .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
      .timeout_o(timeout_o),
      .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [11:0] addr;
      logic        we;
      logic [31:0] wdata;
      int          stalls;
      logic [31:0] prdata;
      logic        slverr;
      int          exp_lat;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_abort;
   } vec_t;

   int          errors = 0;
   int          checks = 0;
   logic        pend_v = 1'b0;
   logic [31:0] pend_rdata = '0;
   logic        pend_err = 1'b0;
   logic [31:0] last_rdata = '0;
   logic        last_err = 1'b0;
   logic        to_exp = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Transaction-level model: response timing and content from stall count alone.
   task automatic ref_model(input logic we, input int stalls, input logic [31:0] prd,
                            input logic slv, output int lat, output logic [31:0] rd,
                            output logic err, output logic abort);
      abort = (stalls >= TO);
      lat   = abort ? TO + 2 : stalls + 3;
      rd    = (abort || we) ? 32'h0 : prd;
      err   = abort ? 1'b1 : slv;
   endtask

   task automatic check_resp();
      chk("rvalid", rvalid_o, pend_v);
      if (pend_v) begin
         last_rdata = pend_rdata;
         last_err   = pend_err;
         pend_v     = 1'b0;
      end
      chk("rdata", rdata_o, last_rdata);
      chk("err", err_o, last_err);
   endtask

   task automatic idle_cycle();
      @(negedge HCLK);
      req_i  = 1'b0;
      PREADY = 1'b0;
      #1;
      chk("gnt_idle", gnt_o, 0);
      check_resp();
      chk("psel_idle", PSEL, 0);
      chk("penable_idle", PENABLE, 0);
      chk("timeout", timeout_o, to_exp);
   endtask

   // Cycle 0 is the grant cycle; the response lands in the caller's next cycle.
   task automatic xfer(input vec_t v, input logic hold);
      for (int k = 0; k < v.exp_lat; k++) begin
         @(negedge HCLK);
         if (k == 0) begin
            req_i       = 1'b1;
            req_addr_i  = v.addr;
            req_we_i    = v.we;
            req_wdata_i = v.wdata;
         end else begin
            req_i = hold;
         end
         PREADY  = (k >= 2) && ((k - 2) == v.stalls);
         PRDATA  = PREADY ? v.prdata : $urandom;
         PSLVERR = PREADY ? v.slverr : 1'($urandom_range(0, 1));
         #1;
         chk("gnt", gnt_o, (k == 0));
         if (k == 0) check_resp();
         else chk("rvalid_busy", rvalid_o, 0);
         chk("psel", PSEL, (k != 0));
         chk("penable", PENABLE, (k >= 2));
         if (k != 0) begin
            chk("paddr", PADDR, v.addr);
            chk("pwrite", PWRITE, v.we);
            chk("pwdata", PWDATA, v.wdata);
         end
         chk("timeout", timeout_o, to_exp);
      end
      pend_v     = 1'b1;
      pend_rdata = v.exp_rdata;
      pend_err   = v.exp_err;
      if (v.exp_abort) to_exp = 1'b1;
   endtask

   vec_t tbl[6];
   vec_t rv;

   initial begin
      tbl[0] = '{12'h004, 1'b1, 32'hDEADBEEF, 0, 32'h0,        1'b0, 3, 32'h0,        1'b0, 1'b0};
      tbl[1] = '{12'h100, 1'b0, 32'h0,        3, 32'h12345678, 1'b0, 6, 32'h12345678, 1'b0, 1'b0};
      tbl[2] = '{12'h040, 1'b0, 32'h0,        0, 32'hCAFEF00D, 1'b1, 3, 32'hCAFEF00D, 1'b1, 1'b0};
      tbl[3] = '{12'h0FC, 1'b1, 32'h55AA55AA, 3, 32'h0,        1'b1, 6, 32'h0,        1'b1, 1'b0};
      tbl[4] = '{12'h200, 1'b0, 32'h0,        9, 32'h0,        1'b0, 6, 32'h0,        1'b1, 1'b1};
      tbl[5] = '{12'h008, 1'b1, 32'h01020304, 1, 32'h0,        1'b0, 4, 32'h0,        1'b0, 1'b0};

      HRESET = 1'b1; req_i = 1'b0; req_addr_i = '0; req_we_i = 1'b0; req_wdata_i = '0;
      PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
      #1;
      chk("rst_gnt", gnt_o, 0);     chk("rst_rvalid", rvalid_o, 0);
      chk("rst_rdata", rdata_o, 0); chk("rst_err", err_o, 0);
      chk("rst_timeout", timeout_o, 0);
      chk("rst_paddr", PADDR, 0);   chk("rst_pwdata", PWDATA, 0);
      chk("rst_pwrite", PWRITE, 0); chk("rst_psel", PSEL, 0);
      chk("rst_penable", PENABLE, 0);
      @(negedge HCLK);
      HRESET = 1'b0;
      idle_cycle();

      for (int i = 0; i < 6; i++) begin
         xfer(tbl[i], 1'b0);
         idle_cycle();
         idle_cycle();
      end

      // Back-to-back writes with req_i held: grant coincides with prior response.
      for (int i = 0; i < 3; i++) begin
         rv = '{12'h010 + 12'(i * 4), 1'b1, 32'hA0000000 + i, 0, 32'h0, 1'b0,
                3, 32'h0, 1'b0, 1'b0};
         xfer(rv, 1'b1);
      end
      idle_cycle();

      // Reset while stalled in ACCESS.
      @(negedge HCLK);
      req_i = 1'b1; req_addr_i = 12'h300; req_we_i = 1'b0; PREADY = 1'b0;
      #1; chk("rst_seq_gnt", gnt_o, 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge HCLK);
         req_i = 1'b0;
      end
      #1; chk("rst_seq_penable_before", PENABLE, 1);
      HRESET = 1'b1;
      #1;
      chk("rst_seq_psel", PSEL, 0);
      chk("rst_seq_penable", PENABLE, 0);
      chk("rst_seq_rvalid", rvalid_o, 0);
      chk("rst_seq_timeout", timeout_o, 0);
      to_exp = 1'b0; pend_v = 1'b0; last_rdata = '0; last_err = 1'b0;
      @(negedge HCLK);
      HRESET = 1'b0;
      idle_cycle();
      xfer(tbl[1], 1'b0);
      idle_cycle();

      for (int i = 0; i < 40; i++) begin
         rv.addr   = 12'($urandom);
         rv.we     = 1'($urandom_range(0, 1));
         rv.wdata  = $urandom;
         rv.stalls = $urandom_range(0, 5);
         rv.prdata = $urandom;
         rv.slverr = 1'($urandom_range(0, 1));
         ref_model(rv.we, rv.stalls, rv.prdata, rv.slverr,
                   rv.exp_lat, rv.exp_rdata, rv.exp_err, rv.exp_abort);
         xfer(rv, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) idle_cycle();
      end
      idle_cycle();
      idle_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
